div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Issue/sequencing controller that sits between the EX stage and the shared iterative divider in the RV32M path.
- Accepts DIV/DIVU/REM/REMU requests with a valid/ready handshake.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) without using the divider.
- Returns a result from a one-entry operand cache when a DIV/REM pair reuses the same operands.
- Otherwise drives the divider and delivers a one-cycle writeback; handles pipeline flush and a divider watchdog.

Parameters:
- DW, 32, operand/result width.
- TIMEOUT, 40, max cycles to wait for div_done before abort (must exceed divider latency).
- TW, 6, width of watchdog counter (2^TW > TIMEOUT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  EX stage presents a divide op.
- req_ready  out  1  request accepted this cycle (req_valid && req_ready).
- req_op  in  2  bit1: 1=REM/REMU, 0=DIV/DIVU; bit0: 1=unsigned.
- req_rs1  in  DW  dividend.
- req_rs2  in  DW  divisor.
- req_rd  in  5  destination register.
- flush_i  in  1  kill in-flight op (branch mispredict/trap).
- div_start  out  1  one-cycle start pulse to divider.
- div_dividend  out  DW  registered dividend, stable from start until done.
- div_divisor  out  DW  registered divisor, stable from start until done.
- div_signed  out  1  signed mode to divider.
- div_quot  in  DW  divider quotient.
- div_rem  in  DW  divider remainder.
- div_done  in  1  divider result valid (level; first high cycle in BUSY/DRAIN is used).
- wb_valid  out  1  one-cycle result strobe.
- wb_rd  out  5  destination register.
- wb_data  out  DW  result.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky watchdog error, cleared by reset only.

Behaviour:
- Reset: all outputs 0, state IDLE, cache_valid 0, counter 0. Reset in any state aborts the op with no wb_valid.
- States: IDLE, BUSY, DRAIN, RESP.
- req_ready = (state==IDLE) && !flush_i.
- IDLE, on accept: latch op, rs1, rs2, rd. Then exactly one of:
  - Special case, next state RESP:
    - rs2==0 → quot=all-ones, rem=rs1 (signed and unsigned).
    - Signed with rs1==100..0 and rs2==all-ones → quot=rs1, rem=0.
  - Cache hit, next state RESP: cache_valid, rs1==c_rs1, rs2==c_rs2, and signedness==c_signed. Result is c_quot or c_rem per op[1].
  - Otherwise, next state BUSY: div_start=1 in the next cycle only; div_dividend, div_divisor and div_signed are driven from the latched values.
- BUSY:
  - Counter increments each cycle.
  - div_done → capture div_quot/div_rem. Cache is updated with operands, signedness, quot and rem; cache_valid=1. Next state RESP.
  - flush_i (takes priority over div_done) → DRAIN.
  - Counter reaching TIMEOUT → err_o=1, cache_valid=0, next state IDLE, no wb.
- DRAIN: wait for div_done (cache NOT updated) or TIMEOUT (err_o=1). Then IDLE, no wb. The divider is never interrupted mid-operation.
- RESP:
  - wb_valid=1 for one cycle with wb_rd and wb_data (quot if op[1]==0, else rem); next state IDLE.
  - flush_i in RESP suppresses wb_valid; state still goes to IDLE.
- Latency:
  - Special case or cache hit: wb_valid 2 cycles after the accept edge (accept, RESP).
  - Divider path: wb_valid the cycle after div_done is sampled.
- Counter clears on entering BUSY and on leaving DRAIN.
- Special-case results never write the cache.
- Back-to-back: a new request is accepted the cycle after RESP (IDLE). Throughput for hits is one op per 2 cycles.
- A request held with req_valid while not ready keeps its operands stable (EX-stage contract); the controller does not sample them.

Test Plan:
- Signed DIV 100/7 (rd=5): one div_start pulse, div_signed=1; model done after 33 cycles → wb_valid one cycle later, wb_data=14, wb_rd=5.
- REM 100,7 immediately after test 1: no div_start, wb_data=2 two cycles after accept. Then REMU with the same operands: cache miss (signedness differs), div_start issued.
- DIVU 5/0 → wb_data=0xFFFF_FFFF; REM 5/0 → wb_data=5. Neither asserts div_start, and a later DIV 5,0 does not hit the cache.
- DIV 0x8000_0000/0xFFFF_FFFF → wb_data=0x8000_0000; REM with the same operands → wb_data=0. No div_start for either.
- Flush 3 cycles after div_start: req_ready stays low until div_done, then IDLE with no wb_valid. Repeating the same op issues a new div_start (cache not written).
- Divider never asserts done: err_o=1 after 40 cycles in BUSY, then IDLE. Next, assert rst mid-BUSY on a fresh op: next cycle all outputs 0, err_o cleared.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Issue controller for the shared iterative divider: resolves RV32M special cases,
// reuses a one-entry result cache, and drives the divider with flush and watchdog handling.
module div_issue_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 40,
  parameter int TW      = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_rs1,
  input  logic [DW-1:0] req_rs2,
  input  logic [4:0]    req_rd,
  input  logic          flush_i,
  output logic          div_start,
  output logic [DW-1:0] div_dividend,
  output logic [DW-1:0] div_divisor,
  output logic          div_signed,
  input  logic [DW-1:0] div_quot,
  input  logic [DW-1:0] div_rem,
  input  logic          div_done,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          busy_o,
  output logic          err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

  state_t        r_state;
  logic [1:0]    r_op;
  logic [4:0]    r_rd;
  logic [DW-1:0] r_a, r_b, r_res;
  logic          r_sgn, r_start, r_err;
  logic [TW-1:0] r_cnt;

  logic          r_c_vld, r_c_sgn;
  logic [DW-1:0] r_c_a, r_c_b, r_c_q, r_c_r;

  logic          w_accept, w_sgn, w_div0, w_ovf, w_hit, w_tmo;
  logic [DW-1:0] w_fast_res, w_div_res;

  assign req_ready = (r_state == IDLE) && !flush_i;
  assign w_accept  = req_valid && req_ready;
  assign w_sgn     = !req_op[0];
  assign w_div0    = (req_rs2 == '0);
  assign w_ovf     = w_sgn && (req_rs1 == {1'b1, {(DW-1){1'b0}}}) && (req_rs2 == '1);
  assign w_hit     = r_c_vld && (req_rs1 == r_c_a) && (req_rs2 == r_c_b) && (w_sgn == r_c_sgn);
  assign w_div_res = r_op[1] ? div_rem : div_quot;
  // >= so a timeout that coincides with a flush still ends the following drain
  assign w_tmo     = (r_cnt >= TW'(TIMEOUT-1));

  always_comb begin
    w_fast_res = r_c_q;
    if (w_div0)      w_fast_res = req_op[1] ? req_rs1 : '1;
    else if (w_ovf)  w_fast_res = req_op[1] ? '0 : req_rs1;
    else             w_fast_res = req_op[1] ? r_c_r : r_c_q;
  end

  assign div_start    = r_start;
  assign div_dividend = r_a;
  assign div_divisor  = r_b;
  assign div_signed   = r_sgn;
  assign wb_valid     = (r_state == RESP) && !flush_i;
  assign wb_rd        = r_rd;
  assign wb_data      = r_res;
  assign busy_o       = (r_state != IDLE);
  assign err_o        = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_rd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sgn   <= 1'b0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_c_vld <= 1'b0;
      r_c_sgn <= 1'b0;
      r_c_a   <= '0;
      r_c_b   <= '0;
      r_c_q   <= '0;
      r_c_r   <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_op  <= req_op;
          r_rd  <= req_rd;
          r_a   <= req_rs1;
          r_b   <= req_rs2;
          r_sgn <= w_sgn;
          if (w_div0 || w_ovf || w_hit) begin
            r_res   <= w_fast_res;
            r_state <= RESP;
          end else begin
            r_start <= 1'b1;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (flush_i) begin
            r_state <= DRAIN;
          end else if (div_done) begin
            r_res   <= w_div_res;
            r_c_vld <= 1'b1;
            r_c_a   <= r_a;
            r_c_b   <= r_b;
            r_c_sgn <= r_sgn;
            r_c_q   <= div_quot;
            r_c_r   <= div_rem;
            r_state <= RESP;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_c_vld <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        // Killed op: let the divider finish so it is never cut off mid-operation
        DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          if (div_done || w_tmo) begin
            if (!div_done) r_err <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed RV32M cases with literal expectations, then
// randomized traffic against a transaction-level model with a divider responder.
module tb_div_issue_ctrl;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, flush_i;
  logic [1:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        div_start, div_signed, div_done;
  logic [31:0] div_dividend, div_divisor, div_quot, div_rem;
  logic        wb_valid, busy_o, err_o;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DW(32), .TIMEOUT(TIMEOUT), .TW(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush_i(flush_i),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_signed(div_signed), .div_quot(div_quot), .div_rem(div_rem), .div_done(div_done),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .busy_o(busy_o), .err_o(err_o)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Architectural answer per RISC-V rules
  function automatic logic [31:0] ref_res(input logic rem, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
    if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
    return rem ? a % b : a / b;
  endfunction

  // Transaction-level model: what the controller owes, not how it is built
  bit          m_on, m_inflight, m_divwait, m_killed, m_resp, m_accepted;
  int          m_waited;
  logic [31:0] m_a, m_b, m_result;
  logic        m_sgn, m_rem, e_start, e_err;
  logic [4:0]  m_rd;
  bit          mc_v;
  logic [31:0] mc_a, mc_b;
  logic        mc_sgn;

  task automatic model_step();
    bit special, hit;
    if (rst) begin
      m_on = 1; m_inflight = 0; m_divwait = 0; m_killed = 0; m_resp = 0; m_accepted = 0;
      m_waited = 0; mc_v = 0; e_err = 0; e_start = 0; m_a = 0; m_b = 0; m_sgn = 0;
      return;
    end
    if (!m_on) return;
    e_start = 0; m_accepted = 0;
    if (!m_inflight) begin
      if (req_valid && !flush_i) begin
        m_accepted = 1; m_inflight = 1;
        m_a = req_rs1; m_b = req_rs2; m_sgn = !req_op[0]; m_rem = req_op[1]; m_rd = req_rd;
        m_result = ref_res(m_rem, m_sgn, m_a, m_b);
        special = (m_b == 0) || (m_sgn && m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF);
        hit = mc_v && mc_a == m_a && mc_b == m_b && mc_sgn == m_sgn;
        if (special || hit) m_resp = 1;
        else begin m_divwait = 1; m_waited = 0; e_start = 1; end
      end
    end else if (m_resp) begin
      m_resp = 0; m_inflight = 0;
    end else begin
      m_waited++;
      if (!m_killed) begin
        if (flush_i) m_killed = 1;
        else if (div_done) begin
          m_divwait = 0; m_resp = 1;
          mc_v = 1; mc_a = m_a; mc_b = m_b; mc_sgn = m_sgn;
        end else if (m_waited >= TIMEOUT) begin
          e_err = 1; mc_v = 0; m_inflight = 0; m_divwait = 0;
        end
      end else if (div_done || m_waited >= TIMEOUT) begin
        if (!div_done) e_err = 1;
        m_inflight = 0; m_divwait = 0; m_killed = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_on) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, !m_inflight && !flush_i});
      chk("busy_o", {31'b0, busy_o}, {31'b0, m_inflight});
      chk("div_start", {31'b0, div_start}, {31'b0, e_start});
      chk("err_o", {31'b0, err_o}, {31'b0, e_err});
      chk("wb_valid", {31'b0, wb_valid}, {31'b0, m_resp && !flush_i});
      if (m_resp && !flush_i) begin
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, m_rd});
        chk("wb_data", wb_data, m_result);
      end
      if (m_divwait) begin
        chk("div_dividend", div_dividend, m_a);
        chk("div_divisor", div_divisor, m_b);
        chk("div_signed", {31'b0, div_signed}, {31'b0, m_sgn});
      end
    end
  end

  // Divider responder and event log
  int          cyc = 0, dv_cnt = -1, dv_lat = 33, n_starts = 0, n_wb = 0;
  int          start_cyc = 0, wb_cyc = 0, acc_cyc = 0;
  bit          dv_hang = 0;
  logic        start_sgn;
  logic [31:0] dv_q, dv_r, wb_data_s;
  logic [4:0]  wb_rd_s;

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    div_done = 1'b0;
    if (rst) dv_cnt = -1;
    else begin
      if (dv_cnt > 0) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          div_done = 1'b1; div_quot = dv_q; div_rem = dv_r; dv_cnt = -1;
        end
      end
      if (div_start) begin
        n_starts++; start_cyc = cyc; start_sgn = div_signed;
        if (div_divisor == 0) begin dv_q = '1; dv_r = div_dividend; end
        else if (div_signed) begin
          dv_q = 32'($signed(div_dividend) / $signed(div_divisor));
          dv_r = 32'($signed(div_dividend) % $signed(div_divisor));
        end else begin
          dv_q = div_dividend / div_divisor; dv_r = div_dividend % div_divisor;
        end
        if (!dv_hang) dv_cnt = dv_lat;
      end
    end
    if (wb_valid) begin n_wb++; wb_cyc = cyc; wb_rd_s = wb_rd; wb_data_s = wb_data; end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    int g = 0;
    while (!req_ready && g < 100) begin tick(); g++; end
    if (g >= 100) chk("ready wait expired", 32'd0, 32'd1);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    acc_cyc = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_wb(input int n0, input int max);
    int k = 0;
    while (n_wb == n0 && k < max) begin tick(); k++; end
    if (n_wb == n0) chk("wb wait expired", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'd7;
      3: return 32'd100;
      4: return 32'hFFFF_FFFF;
      5: return 32'h8000_0000;
      6: return 32'hFFFF_FFF9;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int s0, w0, k;
    logic [31:0] ra, rb;
    rst = 1; req_valid = 0; req_op = 0; req_rs1 = 0; req_rs2 = 0; req_rd = 0;
    flush_i = 0; div_done = 0; div_quot = 0; div_rem = 0;
    tick(); tick();
    chk("rst wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst busy", {31'b0, busy_o}, 32'd0);
    chk("rst err", {31'b0, err_o}, 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    rst = 0;
    tick();

    // Signed DIV through the divider
    dv_lat = 33; s0 = n_starts; w0 = n_wb;
    issue(2'b00, 32'd100, 32'd7, 5'd5);
    wait_wb(w0, 60);
    chk("div starts", n_starts - s0, 32'd1);
    chk("div signed", {31'b0, start_sgn}, 32'd1);
    chk("div latency", wb_cyc - start_cyc, 32'd34);
    chk("div rd", {27'b0, wb_rd_s}, 32'd5);
    chk("div data", wb_data_s, 32'd14);

    // REM with the same operands hits the cache
    s0 = n_starts; w0 = n_wb;
    issue(2'b10, 32'd100, 32'd7, 5'd6);
    chk("hit starts", n_starts - s0, 32'd0);
    chk("hit wb count", n_wb - w0, 32'd1);
    chk("hit latency", wb_cyc - acc_cyc, 32'd1);
    chk("hit data", wb_data_s, 32'd2);

    // REMU misses on signedness
    s0 = n_starts; w0 = n_wb;
    issue(2'b11, 32'd100, 32'd7, 5'd7);
    wait_wb(w0, 60);
    chk("remu starts", n_starts - s0, 32'd1);
    chk("remu signed", {31'b0, start_sgn}, 32'd0);
    chk("remu data", wb_data_s, 32'd2);

    // Divide by zero and signed overflow
    s0 = n_starts;
    w0 = n_wb; issue(2'b01, 32'd5, 32'd0, 5'd1); chk("divu0 data", wb_data_s, 32'hFFFF_FFFF);
    chk("divu0 wb", n_wb - w0, 32'd1);
    w0 = n_wb; issue(2'b10, 32'd5, 32'd0, 5'd2); chk("rem0 data", wb_data_s, 32'd5);
    w0 = n_wb; issue(2'b00, 32'd5, 32'd0, 5'd3); chk("div0 data", wb_data_s, 32'hFFFF_FFFF);
    w0 = n_wb; issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4); chk("ovf div", wb_data_s, 32'h8000_0000);
    w0 = n_wb; issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4); chk("ovf rem", wb_data_s, 32'd0);
    chk("ovf wb", n_wb - w0, 32'd1);
    chk("special starts", n_starts - s0, 32'd0);

    // Flush 3 cycles after start: drain until done, no writeback, cache untouched
    dv_lat = 33; w0 = n_wb;
    issue(2'b00, 32'd1000, 32'd3, 5'd9);
    tick(); tick(); tick();
    flush_i = 1; tick(); flush_i = 0;
    k = 0;
    while (!req_ready && k < 60) begin tick(); k++; end
    chk("flush ready cyc", cyc - start_cyc, 32'd34);
    chk("flush no wb", n_wb - w0, 32'd0);
    s0 = n_starts; w0 = n_wb;
    issue(2'b00, 32'd1000, 32'd3, 5'd9);
    wait_wb(w0, 60);
    chk("reissue starts", n_starts - s0, 32'd1);
    chk("reissue data", wb_data_s, 32'd333);

    // Hung divider: watchdog after 40 busy cycles
    dv_hang = 1; w0 = n_wb;
    issue(2'b00, 32'd7, 32'd2, 5'd3);
    k = 0;
    while (!err_o && k < 60) begin tick(); k++; end
    chk("tmo latency", cyc - start_cyc, 32'd40);
    chk("tmo busy", {31'b0, busy_o}, 32'd0);
    chk("tmo no wb", n_wb - w0, 32'd0);
    dv_hang = 0; dv_lat = 5;
    s0 = n_starts; w0 = n_wb;
    issue(2'b00, 32'd1000, 32'd3, 5'd8);
    wait_wb(w0, 60);
    chk("tmo cache cleared", n_starts - s0, 32'd1);
    chk("err sticky", {31'b0, err_o}, 32'd1);

    // Reset mid-BUSY
    dv_lat = 33;
    issue(2'b01, 32'd9, 32'd4, 5'd12);
    repeat (5) tick();
    rst = 1; tick();
    chk("mid rst busy", {31'b0, busy_o}, 32'd0);
    chk("mid rst err", {31'b0, err_o}, 32'd0);
    chk("mid rst wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("mid rst start", {31'b0, div_start}, 32'd0);
    chk("mid rst dividend", div_dividend, 32'd0);
    chk("mid rst divisor", div_divisor, 32'd0);
    chk("mid rst signed", {31'b0, div_signed}, 32'd0);
    chk("mid rst wb_rd", {27'b0, wb_rd}, 32'd0);
    chk("mid rst wb_data", wb_data, 32'd0);
    rst = 0; tick();

    // Randomized traffic against the model
    ra = 32'd100; rb = 32'd7;
    for (int i = 0; i < 4000; i++) begin
      if (req_valid && m_accepted) req_valid = 1'b0;
      if (!req_valid && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) begin ra = pick(); rb = pick(); end
        req_valid = 1'b1; req_op = 2'($urandom_range(0, 3));
        req_rs1 = ra; req_rs2 = rb; req_rd = 5'($urandom_range(0, 31));
      end
      flush_i = !div_done && ($urandom_range(0, 15) == 0);
      dv_lat = $urandom_range(1, 38);
      tick();
    end
    req_valid = 0; flush_i = 0;
    repeat (50) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
